// File: rtl/tlb_op_ctrl_pkg.sv
// Shared types and constants for the TLB maintenance-op sequencer and the
// INVTLB / TLBSRCH match logic.
package tlb_op_pkg;

  // WB-committed TLB op codes
  typedef enum logic [1:0] {
    OP_RD   = 2'd0,
    OP_WR   = 2'd1,
    OP_FILL = 2'd2,
    OP_INV  = 2'd3
  } req_op_e;

  // INVTLB op field encodings; anything above INV_GA_VA matches nothing
  localparam logic [4:0] INV_ALL0        = 5'd0;
  localparam logic [4:0] INV_ALL1        = 5'd1;
  localparam logic [4:0] INV_G           = 5'd2;
  localparam logic [4:0] INV_NG          = 5'd3;
  localparam logic [4:0] INV_NG_ASID     = 5'd4;
  localparam logic [4:0] INV_NG_ASID_VA  = 5'd5;
  localparam logic [4:0] INV_GA_VA       = 5'd6;

  // Sequencer states
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_RD_WAIT   = 3'd2,
    S_INV_SWEEP = 3'd3,
    S_INV_DRAIN = 3'd4
  } state_e;

  // Page-size encodings held in the entry PS field
  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_4M = 6'd21;

  // VPN compare honouring the entry's page size: a 4M page ignores the
  // low 9 bits of the vppn; any other size compares the full vppn.
  function automatic logic vpn_eq(input logic [18:0] e_vppn,
                                  input logic [18:0] vpn,
                                  input logic [5:0]  e_ps);
    if (e_ps == PS_4M) begin
      return e_vppn[18:9] == vpn[18:9];
    end
    return e_vppn == vpn;
  endfunction

endpackage

// File: rtl/tlb_op_ctrl_if.sv
// WB -> TLB op controller request channel. WB is the master; the controller
// accepts in the cycle it shows req_ready with req_valid high and no flush.
interface tlb_op_ctrl_if #(
  parameter int IDXW = 4
);

  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [IDXW-1:0] csr_index;
  logic [4:0]      inv_op;
  logic [9:0]      inv_asid;
  logic [18:0]     inv_vpn;
  logic            flush;

  modport master (
    output req_valid,
    output req_op,
    output csr_index,
    output inv_op,
    output inv_asid,
    output inv_vpn,
    output flush,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  csr_index,
    input  inv_op,
    input  inv_asid,
    input  inv_vpn,
    input  flush,
    output req_ready
  );

endinterface

// File: rtl/tlb_op_ctrl_inv_match.sv
// Combinational INVTLB entry-match: decides whether one TLB entry is
// selected by an INVTLB op/asid/va triple. Also used by the TLBSRCH path.
module tlb_inv_match
  import tlb_op_pkg::*;
(
  input  logic [4:0]  inv_op,
  input  logic [9:0]  inv_asid,
  input  logic [18:0] inv_vpn,
  input  logic        e_g,
  input  logic [9:0]  e_asid,
  input  logic [18:0] e_vppn,
  input  logic [5:0]  e_ps,
  output logic        match
);

  logic asid_hit;
  logic vpn_hit;

  assign asid_hit = (e_asid == inv_asid);
  assign vpn_hit  = vpn_eq(e_vppn, inv_vpn, e_ps);

  // Select the match rule for the op; unknown ops select nothing
  always_comb begin
    match = 1'b0;
    case (inv_op)
      INV_ALL0,
      INV_ALL1:       match = 1'b1;
      INV_G:          match = e_g;
      INV_NG:         match = !e_g;
      INV_NG_ASID:    match = !e_g && asid_hit;
      INV_NG_ASID_VA: match = !e_g && asid_hit && vpn_hit;
      INV_GA_VA:      match = (e_g || asid_hit) && vpn_hit;
      default:        match = 1'b0;
    endcase
  end

endmodule

// File: rtl/tlb_op_ctrl.sv
// TLB maintenance-op sequencer. Accepts one TLBRD/TLBWR/TLBFILL/INVTLB from
// WB at a time, drives the TLB's single read and write port, and holds the
// pipeline (busy) until the op retires (done).
//
// state       | meaning
// ------------+------------------------------------------------------------
// S_IDLE      | ready; read port follows csr_index so a TLBRD issues at accept
// S_WRITE     | one-cycle full-entry write (TLBWR index or TLBFILL victim)
// S_RD_WAIT   | read data back; load it into the CSRs
// S_INV_SWEEP | issue read of sweep_cnt; clear-compare of previous index
// S_INV_DRAIN | clear-compare of the last entry, then retire
//
// The INVTLB compare/write stage trails the read stage by one cycle because
// read data returns the cycle after the index is presented. The write strobe
// during a sweep is therefore combinational from the returned entry.
module tlb_op_ctrl
  import tlb_op_pkg::*;
#(
  parameter int TLBNUM = 16,
  parameter int IDXW   = 4
) (
  input  logic            clk,
  input  logic            reset,
  tlb_op_ctrl_if.slave    bus,
  output logic [IDXW-1:0] tlb_r_index,
  input  logic            tlb_r_e,
  input  logic            tlb_r_g,
  input  logic [9:0]      tlb_r_asid,
  input  logic [18:0]     tlb_r_vppn,
  input  logic [5:0]      tlb_r_ps,
  output logic            tlb_we,
  output logic [IDXW-1:0] tlb_w_index,
  output logic            tlb_w_clr,
  output logic            csr_rd_we,
  output logic            busy,
  output logic            done
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TLBNUM - 1);

  state_e          state;
  logic [IDXW-1:0] fill_cnt;
  logic [IDXW-1:0] sweep_cnt;
  logic [IDXW-1:0] idx_q;
  logic [IDXW-1:0] cmp_idx_q;
  logic            cmp_valid_q;
  logic            wr_we_q;
  logic            done_q;
  logic            csr_rd_we_q;
  logic [4:0]      inv_op_q;
  logic [9:0]      inv_asid_q;
  logic [18:0]     inv_vpn_q;
  logic            accept;
  logic            inv_hit;

  assign busy          = (state != S_IDLE);
  assign bus.req_ready = !busy;
  assign accept        = bus.req_valid && !bus.flush && !busy;

  // Free-running TLBFILL victim pointer; wraps naturally at TLBNUM
  always_ff @(posedge clk) begin
    if (reset) begin
      fill_cnt <= '0;
    end else begin
      fill_cnt <= fill_cnt + 1'b1;
    end
  end

  // Op sequencer: state, sweep pointer, latched operands, registered strobes
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      sweep_cnt   <= '0;
      idx_q       <= '0;
      cmp_idx_q   <= '0;
      cmp_valid_q <= 1'b0;
      wr_we_q     <= 1'b0;
      done_q      <= 1'b0;
      csr_rd_we_q <= 1'b0;
      inv_op_q    <= '0;
      inv_asid_q  <= '0;
      inv_vpn_q   <= '0;
    end else begin
      wr_we_q     <= 1'b0;
      done_q      <= 1'b0;
      csr_rd_we_q <= 1'b0;
      cmp_valid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            idx_q      <= bus.csr_index;
            inv_op_q   <= bus.inv_op;
            inv_asid_q <= bus.inv_asid;
            inv_vpn_q  <= bus.inv_vpn;
            case (req_op_e'(bus.req_op))
              OP_RD: begin
                state       <= S_RD_WAIT;
                csr_rd_we_q <= 1'b1;
                done_q      <= 1'b1;
              end
              OP_WR: begin
                state   <= S_WRITE;
                wr_we_q <= 1'b1;
                done_q  <= 1'b1;
              end
              OP_FILL: begin
                state   <= S_WRITE;
                idx_q   <= fill_cnt;
                wr_we_q <= 1'b1;
                done_q  <= 1'b1;
              end
              default: begin
                state     <= S_INV_SWEEP;
                sweep_cnt <= '0;
              end
            endcase
          end
        end
        S_WRITE,
        S_RD_WAIT: begin
          state <= S_IDLE;
        end
        S_INV_SWEEP: begin
          cmp_valid_q <= 1'b1;
          cmp_idx_q   <= sweep_cnt;
          sweep_cnt   <= sweep_cnt + 1'b1;
          if (sweep_cnt == LAST_IDX) begin
            state  <= S_INV_DRAIN;
            done_q <= 1'b1;
          end
        end
        S_INV_DRAIN: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  tlb_inv_match u_inv_match (
    .inv_op   (inv_op_q),
    .inv_asid (inv_asid_q),
    .inv_vpn  (inv_vpn_q),
    .e_g      (tlb_r_g),
    .e_asid   (tlb_r_asid),
    .e_vppn   (tlb_r_vppn),
    .e_ps     (tlb_r_ps),
    .match    (inv_hit)
  );

  // Read-port index: live csr_index in IDLE so TLBRD issues on accept
  always_comb begin
    tlb_r_index = idx_q;
    if (state == S_IDLE) begin
      tlb_r_index = bus.csr_index;
    end else if (state == S_INV_SWEEP) begin
      tlb_r_index = sweep_cnt;
    end
  end

  // Write port: sweep compare stage clears E only; WRITE state writes full entry
  always_comb begin
    tlb_we      = wr_we_q || (cmp_valid_q && inv_hit && tlb_r_e);
    tlb_w_index = cmp_valid_q ? cmp_idx_q : idx_q;
    tlb_w_clr   = cmp_valid_q;
  end

  assign done      = done_q;
  assign csr_rd_we = csr_rd_we_q;

endmodule
